// File: rtl/mpu_window_builder.sv
// Packs N_SAMPLES signed samples into one flat window and flags movement when the peak-to-peak spread exceeds MOV_THRESH.
// One sample per cycle while filling; window_valid rises one cycle after the last accept and holds until window_ready.
module mpu_window_builder #(
  parameter int N_SAMPLES  = 30,
  parameter int SAMPLE_W   = 32,
  parameter int MOV_THRESH = 2000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          sample_valid,
  input  logic signed [SAMPLE_W-1:0]    sample_data,
  output logic                          sample_ready,
  output logic [N_SAMPLES*SAMPLE_W-1:0] mpu,
  output logic                          mov,
  output logic                          window_valid,
  input  logic                          window_ready,
  output logic [4:0]                    fill_level,
  output logic                          overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [4:0]              LAST   = 5'(N_SAMPLES - 1);
  localparam logic signed [SAMPLE_W:0] THRESH = (SAMPLE_W + 1)'(MOV_THRESH);

  logic [1:0]                 state;
  logic signed [SAMPLE_W-1:0] trk_min;
  logic signed [SAMPLE_W-1:0] trk_max;
  logic signed [SAMPLE_W-1:0] nxt_min;
  logic signed [SAMPLE_W-1:0] nxt_max;
  logic signed [SAMPLE_W:0]   spread;
  logic                       accept;

  assign accept = sample_valid & sample_ready;

  // Spread is taken one bit wider than a sample so full-scale extremes cannot wrap.
  always_comb begin
    nxt_min = trk_min;
    nxt_max = trk_max;
    if (fill_level == 5'd0) begin
      nxt_min = sample_data;
      nxt_max = sample_data;
    end else begin
      if (sample_data < trk_min) nxt_min = sample_data;
      if (sample_data > trk_max) nxt_max = sample_data;
    end
    spread = {nxt_max[SAMPLE_W-1], nxt_max} - {nxt_min[SAMPLE_W-1], nxt_min};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      sample_ready <= 1'b0;
      window_valid <= 1'b0;
      mov          <= 1'b0;
      overrun      <= 1'b0;
      fill_level   <= 5'd0;
      mpu          <= '0;
      trk_min      <= '0;
      trk_max      <= '0;
    end else if (clear && state != S_IDLE) begin
      // A sample handshaking alongside clear is dropped, and clear beats window_ready.
      state        <= S_FILL;
      sample_ready <= 1'b1;
      window_valid <= 1'b0;
      mov          <= 1'b0;
      overrun      <= 1'b0;
      fill_level   <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state        <= S_FILL;
          sample_ready <= 1'b1;
        end
        S_FILL: begin
          if (accept) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
              if (fill_level == 5'(i)) mpu[i*SAMPLE_W +: SAMPLE_W] <= sample_data;
            end
            trk_min    <= nxt_min;
            trk_max    <= nxt_max;
            fill_level <= fill_level + 5'd1;
            if (fill_level == LAST) begin
              state        <= S_HOLD;
              sample_ready <= 1'b0;
              window_valid <= 1'b1;
              mov          <= (spread > THRESH);
            end
          end
        end
        S_HOLD: begin
          if (sample_valid) overrun <= 1'b1;
          if (window_ready) begin
            state        <= S_FILL;
            sample_ready <= 1'b1;
            window_valid <= 1'b0;
            fill_level   <= 5'd0;
          end
        end
        default: begin
          state        <= S_IDLE;
          sample_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mpu_window_builder.md
# mpu_window_builder

Producer side of the gesture-recognition sample window. Accepts signed accelerometer samples one at a time over a valid/ready stream, packs 30 consecutive samples into the flat 960-bit window consumed by the letter recognizer, and derives the `mov` movement flag from the window's peak-to-peak spread. It sits between the MPU sample front end and the recognizer, presenting one complete window at a time with a valid/ready handshake.

## Interface
- `N_SAMPLES`, 30, number of samples per window.
- `SAMPLE_W`, 32, signed sample width in bits.
- `MOV_THRESH`, 2000, signed peak-to-peak threshold; `mov` = 1 when (max − min) > `MOV_THRESH`.

- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush: discards the partial or held window and clears `overrun`.
- `sample_valid`  in  1  `sample_data` valid.
- `sample_data`  in  `SAMPLE_W`  signed accelerometer sample.
- `sample_ready`  out  1  builder accepts a sample this cycle.
- `mpu`  out  `N_SAMPLES*SAMPLE_W`  packed window; sample i at bits [32i+31 : 32i]; sample 0 = first accepted.
- `mov`  out  1  movement flag for the presented window.
- `window_valid`  out  1  `mpu`/`mov` hold a complete window.
- `window_ready`  in  1  consumer takes the window.
- `fill_level`  out  5  samples accepted into the current window (0..30).
- `overrun`  out  1  sticky: `sample_valid` was high while in HOLD.

## Operation
- States: IDLE, FILL, HOLD. All outputs registered.
- Reset (`reset`=0): state IDLE; `sample_ready`, `window_valid`, `mov`, `overrun` = 0; `fill_level` = 0; `mpu` = 0; min/max trackers = 0.
- IDLE → FILL on the first edge after reset release; `sample_ready` = 1 in FILL.
- FILL: on accept (`sample_valid` & `sample_ready`), write `sample_data` to slot `fill_level` and increment `fill_level`. On the first sample, load min = max = sample. On later samples, update min/max with signed compare.
- The 30th accept moves the block to HOLD. `mov` is computed from the final min/max including the 30th sample. The difference is formed at `SAMPLE_W`+1 bits sign-extended, so it cannot overflow (e.g. max = 2^31−1, min = −2^31).
- HOLD: `window_valid` = 1, `sample_ready` = 0, and `mpu`/`mov`/`fill_level` = 30 are stable. On `window_ready`=1 the block returns to FILL with `fill_level` = 0.
- `sample_valid`=1 in HOLD sets `overrun`. The sample is not stored. `overrun` stays set until `clear` or reset.
- `clear`=1 in any state except IDLE:
  - next state FILL, `fill_level` = 0, `window_valid` = 0, `overrun` = 0, `mov` = 0;
  - a sample handshaking in the same cycle is discarded;
  - `clear` takes priority over `window_ready`.
- `mpu` slots not yet rewritten in FILL keep stale data. The consumer samples `mpu` only while `window_valid` = 1.

## Timing
- Accept at edge k → `fill_level` increments at edge k.
- Sustained `sample_valid`=1: one sample per cycle.
- 30th accept at edge k → `window_valid`=1, `sample_ready`=0, and `mov` valid after edge k. Latency from the last sample is 1 cycle.
- Handshake (`window_valid` & `window_ready`) at edge m → after edge m: `window_valid`=0, `sample_ready`=1, `fill_level`=0.
- Back-to-back windows: minimum period is 31 cycles (30 fill + 1 hold) with `window_ready` tied high.
- `clear` at edge c → FILL state visible after edge c.
- Reset asserted mid-window: immediate return to reset values. The FILL restart follows the IDLE rule.

## Test plan
- Reset release, samples 0..29 = 10·i with `window_ready`=0:
  - `window_valid` rises one cycle after the 30th accept;
  - `mpu`[31:0] = 0 and `mpu`[959:928] = 290;
  - `mov` = 0, since spread 290 ≤ 2000.
- Window with samples −1500 and +600, rest 0: spread 2100 → `mov` = 1. Spread of exactly 2000 → `mov` = 0.
- Extremes: sample 0 = −2^31, sample 5 = 2^31−1 → `mov` = 1 (no wrap).
- `window_ready` held low for 5 cycles with `sample_valid` high throughout:
  - `sample_ready` = 0 and `mpu` stays unchanged;
  - `overrun` = 1, and it stays 1 after the handshake until `clear`.
- `clear` after 12 samples, coincident with a valid sample: `fill_level` = 0 next cycle and no `window_valid`. The next 30 samples form a window, and slot 0 holds the first sample after `clear`.
- `reset` pulsed low at `fill_level` = 17: all outputs return to reset values at once. After release the block accepts a full fresh window.
